// File: rtl/alu_op_scheduler_if.sv
// Bus bundle for alu_op_scheduler: two command requesters, the ALU operand/enable
// side and the response port. master = scheduler, slave = its environment.
interface alu_op_scheduler_if #(
  parameter int WIDTH = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [3:0]       req0_fun;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [3:0]       req1_fun;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic [WIDTH-1:0] ALU_A;
  logic [WIDTH-1:0] ALU_B;
  logic [3:0]       ALU_FUN;
  logic             Arith_Enable;
  logic             Logic_Enable;
  logic             CMP_Enable;
  logic             Shift_Enable;
  logic [WIDTH-1:0] ALU_OUT;
  logic             ALU_flag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;

  modport master (
    input  req0_valid, req0_fun, req0_a, req0_b,
    input  req1_valid, req1_fun, req1_a, req1_b,
    input  ALU_OUT, ALU_flag, rsp_ready,
    output req0_ready, req1_ready,
    output ALU_A, ALU_B, ALU_FUN,
    output Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable,
    output rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    output req0_valid, req0_fun, req0_a, req0_b,
    output req1_valid, req1_fun, req1_a, req1_b,
    output ALU_OUT, ALU_flag, rsp_ready,
    input  req0_ready, req1_ready,
    input  ALU_A, ALU_B, ALU_FUN,
    input  Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable,
    input  rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu_op_scheduler.sv
// Round-robin scheduler sharing one ALU between two requesters.
// Define SCHED_TIMEOUT_EN to add a WAIT-state timeout producing an error response.
module alu_op_scheduler #(
  parameter int WIDTH = 16
`ifdef SCHED_TIMEOUT_EN
  , parameter int TIMEOUT = 4
`endif
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  alu_op_scheduler_if.master    bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic             r_ptr;
  logic [3:0]       r_fun;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_id;
  logic [WIDTH-1:0] r_rspData;
  logic             w_anyValid;
  logic             w_grantId;
  logic             w_accept;
  logic             w_timeout;

  // Pointer names the preferred requester; the other wins only when the preferred is idle.
  assign w_anyValid = bus.req0_valid | bus.req1_valid;
  assign w_grantId  = r_ptr ? bus.req1_valid : ~bus.req0_valid;
  assign w_accept   = (r_state == IDLE) & w_anyValid;

`ifdef SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_waitCnt;
  logic          r_rspErr;

  assign w_timeout = (r_state == WAIT) & ~bus.ALU_flag & (r_waitCnt == CW'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || r_state != WAIT) begin
      r_waitCnt <= '0;
    end else if (!bus.ALU_flag) begin
      r_waitCnt <= r_waitCnt + CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rspErr <= 1'b0;
    end else if (r_state == WAIT) begin
      if (bus.ALU_flag) begin
        r_rspErr <= 1'b0;
      end else if (w_timeout) begin
        r_rspErr <= 1'b1;
      end
    end
  end

  assign bus.rsp_err = r_rspErr;
`else
  assign w_timeout   = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:    if (w_anyValid) w_nextState = ISSUE;
      ISSUE:   w_nextState = WAIT;
      WAIT:    if (bus.ALU_flag || w_timeout) w_nextState = RESP;
      RESP:    if (bus.rsp_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Command latch, pointer update and result capture.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr     <= 1'b0;
      r_fun     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_id      <= 1'b0;
      r_rspData <= '0;
    end else begin
      if (w_accept) begin
        r_fun <= w_grantId ? bus.req1_fun : bus.req0_fun;
        r_a   <= w_grantId ? bus.req1_a   : bus.req0_a;
        r_b   <= w_grantId ? bus.req1_b   : bus.req0_b;
        r_id  <= w_grantId;
        r_ptr <= ~w_grantId;
      end
      if (r_state == WAIT) begin
        if (bus.ALU_flag) begin
          r_rspData <= bus.ALU_OUT;
        end else if (w_timeout) begin
          r_rspData <= '0;
        end
      end
    end
  end

  always_comb begin
    bus.req0_ready   = w_accept & ~w_grantId;
    bus.req1_ready   = w_accept &  w_grantId;
    bus.Arith_Enable = (r_state == ISSUE) & (r_fun[3:2] == 2'b00);
    bus.Logic_Enable = (r_state == ISSUE) & (r_fun[3:2] == 2'b01);
    bus.CMP_Enable   = (r_state == ISSUE) & (r_fun[3:2] == 2'b10);
    bus.Shift_Enable = (r_state == ISSUE) & (r_fun[3:2] == 2'b11);
    bus.rsp_valid    = (r_state == RESP);
  end

  assign bus.ALU_A    = r_a;
  assign bus.ALU_B    = r_b;
  assign bus.ALU_FUN  = r_fun;
  assign bus.rsp_id   = r_id;
  assign bus.rsp_data = r_rspData;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed testbench for alu_op_scheduler with a registered ALU model;
// expectations follow SCHED_TIMEOUT_EN when it is defined.
module tb_alu_op_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errs = 0;
  logic flagEn = 1'b1;
  logic forceFlag = 1'b0;

  alu_op_scheduler_if #(.WIDTH(16)) bus ();

  alu_op_scheduler dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Registered ALU: flag and result one cycle after any enable.
  always @(posedge clk) begin
    bus.ALU_flag <= ((bus.Arith_Enable | bus.Logic_Enable | bus.CMP_Enable | bus.Shift_Enable) & flagEn) | forceFlag;
    if (forceFlag) bus.ALU_OUT <= 16'h1234;
    else begin
      case (bus.ALU_FUN[3:2])
        2'b00:   bus.ALU_OUT <= bus.ALU_A + bus.ALU_B;
        2'b01:   bus.ALU_OUT <= bus.ALU_A & bus.ALU_B;
        2'b10:   bus.ALU_OUT <= {15'd0, bus.ALU_A == bus.ALU_B};
        default: bus.ALU_OUT <= bus.ALU_A >> 1;
      endcase
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [3:0] f0, input logic [15:0] a0, input logic [15:0] b0,
                               input logic v1, input logic [3:0] f1, input logic [15:0] a1, input logic [15:0] b1);
    bus.req0_valid = v0; bus.req0_fun = f0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_valid = v1; bus.req1_fun = f1; bus.req1_a = a1; bus.req1_b = b1;
    #1;
  endtask

  function automatic logic [3:0] enables();
    return {bus.Arith_Enable, bus.Logic_Enable, bus.CMP_Enable, bus.Shift_Enable};
  endfunction

  // Full command with rsp_ready high: grant, ISSUE, WAIT, RESP, back to IDLE.
  task automatic doCommand(input logic expId, input logic [3:0] expEn, input logic [15:0] expData, input logic drop);
    int n = 0;
    while (!(bus.req0_ready | bus.req1_ready) && n < 10) begin
      cyc();
      n++;
    end
    checkOutput("grant_wait", n < 10, 1);
    checkOutput("both_ready", bus.req0_ready & bus.req1_ready, 0);
    checkOutput("grant_id", bus.req1_ready, expId);
    cyc();
    if (drop) begin
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
    end
    checkOutput("issue_enables", enables(), expEn);
    checkOutput("issue_ready", bus.req0_ready | bus.req1_ready, 0);
    cyc();
    checkOutput("wait_enables", enables(), 0);
    checkOutput("wait_rsp_valid", bus.rsp_valid, 0);
    cyc();
    checkOutput("rsp_valid", bus.rsp_valid, 1);
    checkOutput("rsp_id", bus.rsp_id, expId);
    checkOutput("rsp_data", bus.rsp_data, expData);
    checkOutput("rsp_err", bus.rsp_err, 0);
    cyc();
    checkOutput("rsp_done", bus.rsp_valid, 0);
  endtask

  initial begin
    bus.rsp_ready = 1'b1;
    applyStimulus(0, 4'h0, 16'h0, 16'h0, 0, 4'h0, 16'h0, 16'h0);
    cyc();
    cyc();
    checkOutput("reset_enables", enables(), 0);
    checkOutput("reset_rsp_valid", bus.rsp_valid, 0);
    checkOutput("reset_alu_a", bus.ALU_A, 0);
    checkOutput("reset_alu_fun", bus.ALU_FUN, 0);
    checkOutput("reset_rsp_data", bus.rsp_data, 0);
    rst = 1'b0;

    // Shift command from requester 0
    applyStimulus(1, 4'b1100, 16'h0008, 16'h0000, 0, 4'h0, 16'h0, 16'h0);
    checkOutput("shift_ready0", bus.req0_ready, 1);
    doCommand(0, 4'b0001, 16'h0004, 1);
    checkOutput("shift_alu_a", bus.ALU_A, 16'h0008);

    // Round robin from reset: 0,1,0,1
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    applyStimulus(1, 4'b0000, 16'h0003, 16'h0005, 1, 4'b0100, 16'h00F0, 16'h003C);
    doCommand(0, 4'b1000, 16'h0008, 0);
    doCommand(1, 4'b0100, 16'h0030, 0);
    doCommand(0, 4'b1000, 16'h0008, 0);
    doCommand(1, 4'b0100, 16'h0030, 1);

    // Remaining unit decodes
    applyStimulus(1, 4'b0000, 16'h7FFF, 16'h0001, 0, 4'h0, 16'h0, 16'h0);
    doCommand(0, 4'b1000, 16'h8000, 1);
    applyStimulus(0, 4'h0, 16'h0, 16'h0, 1, 4'b1000, 16'h0005, 16'h0005);
    doCommand(1, 4'b0010, 16'h0001, 1);

    // Back-pressure on the response port
    bus.rsp_ready = 1'b0;
    applyStimulus(1, 4'b0100, 16'hFF00, 16'h0FF0, 0, 4'h0, 16'h0, 16'h0);
    checkOutput("bp_ready0", bus.req0_ready, 1);
    cyc();
    applyStimulus(0, 4'h0, 16'h0, 16'h0, 1, 4'b0000, 16'h0001, 16'h0001);
    cyc();
    cyc();
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_rsp_valid", bus.rsp_valid, 1);
      checkOutput("bp_rsp_data", bus.rsp_data, 16'h0F00);
      checkOutput("bp_rsp_id", bus.rsp_id, 0);
      checkOutput("bp_req1_ready", bus.req1_ready, 0);
      cyc();
    end
    bus.rsp_ready = 1'b1;
    #1;
    checkOutput("bp_release_valid", bus.rsp_valid, 1);
    cyc();
    checkOutput("bp_idle_valid", bus.rsp_valid, 0);
    checkOutput("bp_idle_req1_ready", bus.req1_ready, 1);
    bus.req1_valid = 1'b0;
    cyc();
    checkOutput("drop_no_issue", enables(), 0);
    checkOutput("drop_no_ready", bus.req1_ready, 0);

    // Reset during WAIT, then pointer restarts at 0
    applyStimulus(1, 4'b1000, 16'h0005, 16'h0005, 0, 4'h0, 16'h0, 16'h0);
    checkOutput("rstw_ready0", bus.req0_ready, 1);
    cyc();
    bus.req0_valid = 1'b0;
    checkOutput("rstw_cmp_en", enables(), 4'b0010);
    cyc();
    rst = 1'b1;
    cyc();
    checkOutput("rstw_rsp_valid", bus.rsp_valid, 0);
    checkOutput("rstw_enables", enables(), 0);
    checkOutput("rstw_alu_a", bus.ALU_A, 0);
    checkOutput("rstw_alu_b", bus.ALU_B, 0);
    checkOutput("rstw_alu_fun", bus.ALU_FUN, 0);
    rst = 1'b0;
    applyStimulus(1, 4'b0000, 16'h0001, 16'h0002, 1, 4'b1100, 16'h0080, 16'h0000);
    doCommand(0, 4'b1000, 16'h0003, 0);
    doCommand(1, 4'b0001, 16'h0040, 1);

    // Unit never answers
    flagEn = 1'b0;
    applyStimulus(1, 4'b0100, 16'h00FF, 16'h0F0F, 0, 4'h0, 16'h0, 16'h0);
    checkOutput("to_ready0", bus.req0_ready, 1);
    cyc();
    bus.req0_valid = 1'b0;
    cyc();
`ifdef SCHED_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      checkOutput("to_wait_valid", bus.rsp_valid, 0);
      cyc();
    end
    checkOutput("to_rsp_valid", bus.rsp_valid, 1);
    checkOutput("to_rsp_err", bus.rsp_err, 1);
    checkOutput("to_rsp_data", bus.rsp_data, 0);
`else
    for (int i = 0; i < 8; i++) begin
      checkOutput("to_wait_valid", bus.rsp_valid, 0);
      cyc();
    end
    forceFlag = 1'b1;
    cyc();
    forceFlag = 1'b0;
    checkOutput("to_flag_wait", bus.rsp_valid, 0);
    cyc();
    checkOutput("to_rsp_valid", bus.rsp_valid, 1);
    checkOutput("to_rsp_err", bus.rsp_err, 0);
    checkOutput("to_rsp_data", bus.rsp_data, 16'h1234);
`endif
    cyc();
    checkOutput("to_done", bus.rsp_valid, 0);
    flagEn = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule

// File: doc/alu_op_scheduler.md
# alu_op_scheduler

Shares the 16-bit ALU (arithmetic, logic, compare and shift units) between two command requesters. It arbitrates round-robin, latches the winning command, and drives the operand bus and exactly one unit enable for one cycle. It then waits for the unit's registered flag, captures the result and returns it on a response port with back-pressure. It sits between the system controller / register-file command sources and the ALU top.

## Interface
- WIDTH, 16, operand/result width
- TIMEOUT, 4, max cycles in WAIT before error response (only with SCHED_TIMEOUT_EN)

- CLK  input  1  system clock; all logic on rising edge
- RST  input  1  reset, synchronous and active-high
- req0_valid / req1_valid  input  1  command request
- req0_ready / req1_ready  output  1  command accepted this cycle
- req0_fun / req1_fun  input  4  ALU function code
- req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands
- ALU_A, ALU_B  output  WIDTH  operands to ALU
- ALU_FUN  output  4  function code to ALU
- Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable  output  1  unit enables
- ALU_OUT  input  WIDTH  muxed registered unit result
- ALU_flag  input  1  muxed registered unit valid flag
- rsp_valid  output  1  response available
- rsp_ready  input  1  response consumer ready
- rsp_id  output  1  requester that issued the command
- rsp_data  output  WIDTH  captured result
- rsp_err  output  1  timeout error (0 when macro absent)

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Reset: state IDLE, rr pointer 0. All outputs are 0 at reset.
- IDLE: grant = pointer's requester if valid, else other if valid. reqN_ready = (state==IDLE) & grant==N. It is combinational, so at most one is high.
- On handshake: latch fun/a/b/id; pointer <= ~id; -> ISSUE. No valid: stay IDLE.
- ISSUE (1 cycle): one-hot enable decoded from latched fun[3:2]: 00 Arith, 01 Logic, 10 CMP, 11 Shift. -> WAIT.
- Enables are all 0 in every other state.
- ALU_A/ALU_B/ALU_FUN: driven from latch registers, stable from ISSUE through RESP. Zero until first accept.
- WAIT: when ALU_flag==1, rsp_data <= ALU_OUT, rsp_err <= 0, -> RESP. ALU_OUT is not sampled when the flag is 0.
- RESP: rsp_valid=1, rsp_id/rsp_data/rsp_err held stable until rsp_ready. On rsp_valid&rsp_ready -> IDLE.
- A new request is not accepted in the same cycle as a response handshake.
- Simultaneous requests: pointer decides. Both requesters continuously valid alternate 0,1,0,1 starting from 0 after reset.
- A requester deasserting valid while not granted is legal. The request is lost with no side effects.
- RST mid-operation: immediate return to IDLE next edge. Enables, rsp_valid and the pointer clear. The in-flight result is discarded.

## Timing
- Accept at edge t (IDLE); enable high during cycle t+1 (ISSUE).
- Unit flag visible in cycle t+2 (WAIT); rsp_valid high from cycle t+3.
- Minimum accept-to-rsp_valid: 3 cycles. Minimum issue interval: 4 cycles (RESP with rsp_ready=1, then IDLE).
- Enables are exactly one cycle wide per command, never overlapping.
- rsp_ready low: scheduler holds RESP indefinitely; req*_ready stay 0.

## Configuration
- SCHED_TIMEOUT_EN defined:
  - WAIT counter counts cycles without ALU_flag.
  - On reaching TIMEOUT: rsp_data <= 0, rsp_err <= 1, -> RESP.
  - Counter clears on entry to WAIT.
- Undefined: no counter; WAIT persists until ALU_flag; rsp_err constant 0.

## Test plan
- Reset then req0 fun=4'b1100, a=16'h0008 -> Shift_Enable pulses 1 cycle, rsp_valid 3 cycles after accept, rsp_id=0, rsp_data=16'h0004 (model: unit returns a>>1).
- req0 and req1 valid together, repeated 4 commands -> grant order 0,1,0,1. Enables pulse once each, never two high.
- fun=4'b0000 / 4'b0100 / 4'b1000 -> Arith / Logic / CMP enable respectively; others 0.
- rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_data stable; req1_ready stays 0; on release response handshake then IDLE.
- RST asserted during WAIT -> next cycle all outputs 0, state IDLE. A following req1 accepted normally with pointer 0 priority.
- SCHED_TIMEOUT_EN, TIMEOUT=4, ALU_flag held 0 -> rsp_valid with rsp_err=1, rsp_data=0 after 4 WAIT cycles. Without macro, no response until the flag is driven high.
